// File: rtl/ysyx_22041752_msu_pkg.sv
// Shared types for the memory stage: pipeline bus layouts, widths and FSM encoding.
package ysyx_22041752_msu_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned STRB_W     = 8;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned ES_TO_MS_W = 203;
  localparam int unsigned MS_TO_WS_W = 134;
  localparam int unsigned FORWARD_W  = 71;

  // EX->MEM payload, MSB first
  typedef struct packed {
    logic            mem_re;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            rf_we;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] es_result;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
  } es_to_ms_t;

  // MEM->WB payload, MSB first
  typedef struct packed {
    logic            rf_we;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] ms_r;
    logic [XLEN-1:0] pc;
  } ms_to_ws_t;

  // Bypass / load-use information back to EX
  typedef struct packed {
    logic            fwd_valid;
    logic            fwd_ready;
    logic [XLEN-1:0] ms_r;
    logic [RD_W-1:0] rd;
  } forward_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } ms_state_e;

endpackage

// File: rtl/ysyx_22041752_msu_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
interface ysyx_22041752_msu_if;
  import ysyx_22041752_msu_pkg::*;

  logic              data_req;
  logic              data_wr;
  logic [XLEN-1:0]   data_addr;
  logic [XLEN-1:0]   data_wdata;
  logic [STRB_W-1:0] data_wstrb;
  logic              data_gnt;
  logic              data_rvalid;
  logic [XLEN-1:0]   data_rdata;

  modport master (
    output data_req, data_wr, data_addr, data_wdata, data_wstrb,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_addr, data_wdata, data_wstrb,
    output data_gnt, data_rvalid, data_rdata
  );

endinterface

// File: rtl/ysyx_22041752_msu_lsu_align.sv
// Byte-lane alignment: store strobe/data placement and load extract with sign/zero extension.
module ysyx_22041752_msu_lsu_align
  import ysyx_22041752_msu_pkg::*;
(
  input  logic [2:0]        off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   st_data,
  input  logic [XLEN-1:0]   ld_word,
  output logic [STRB_W-1:0] wstrb_c,
  output logic [XLEN-1:0]   wdata_c,
  output logic [XLEN-1:0]   ld_r_c
);

  logic [STRB_W-1:0] base;
  logic [5:0]        sh;
  logic [XLEN-1:0]   shifted;

  assign sh = {off, 3'b000};

  always_comb begin
    base = 8'h01;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
  end

  // Misaligned accesses simply lose the strobe bits shifted past lane 7
  assign wstrb_c = base << off;
  assign wdata_c = st_data << sh;
  assign shifted = ld_word >> sh;

  always_comb begin
    ld_r_c = shifted;
    case (size)
      2'd0:    ld_r_c = is_unsigned ? XLEN'(shifted[7:0])
                                    : {{56{shifted[7]}}, shifted[7:0]};
      2'd1:    ld_r_c = is_unsigned ? XLEN'(shifted[15:0])
                                    : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    ld_r_c = is_unsigned ? XLEN'(shifted[31:0])
                                    : {{32{shifted[31]}}, shifted[31:0]};
      default: ld_r_c = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22041752_msu.sv
// Memory pipeline stage: holds one EX result, runs load/store transactions on the
// data bus, and hands the result to WB with bypass info for EX.
module ysyx_22041752_msu
  import ysyx_22041752_msu_pkg::*;
#(
  parameter int unsigned ES_TO_MS_BUS_WD = ES_TO_MS_W,
  parameter int unsigned MS_TO_WS_BUS_WD = MS_TO_WS_W,
  parameter int unsigned FORWARD_BUS_WD  = FORWARD_W
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [FORWARD_BUS_WD-1:0]  ms_forward_bus,
  ysyx_22041752_msu_if.master        mem
);

  es_to_ms_t         in_bus;
  es_to_ms_t         pl;
  ms_state_e         state;
  ms_to_ws_t         ws_bus;
  forward_t          fwd;

  logic              ms_valid;
  logic              ms_ready_go;
  logic              is_mem;
  logic              accept;
  logic              accept_mem;
  logic              req_q;
  logic [XLEN-1:0]   rbuf;
  logic [XLEN-1:0]   ld_r;
  logic [XLEN-1:0]   ms_r;
  logic [XLEN-1:0]   st_wdata;
  logic [STRB_W-1:0] st_wstrb;

  assign in_bus      = es_to_ms_t'(es_to_ms_bus);
  assign is_mem      = pl.mem_re | pl.mem_we;
  assign ms_ready_go = ms_valid && (!is_mem || state == ST_DONE);
  assign ms_allowin  = reset || !ms_valid || (ms_ready_go && ws_allowin);
  assign accept      = es_to_ms_valid && ms_allowin && !reset;
  assign accept_mem  = accept && (in_bus.mem_re || in_bus.mem_we);

  assign ms_to_ws_valid = !reset && ms_valid && ms_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // Payload and response buffer carry no reset; ms_valid/state qualify them
  always_ff @(posedge clk) begin
    if (accept) begin
      pl <= in_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_WAIT && mem.data_rvalid) begin
      rbuf <= mem.data_rdata;
    end
  end

  // Transaction FSM; a newly accepted memory op always restarts at REQ
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      req_q <= 1'b0;
    end else if (accept_mem) begin
      state <= ST_REQ;
      req_q <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: state <= ST_IDLE;
        ST_REQ: begin
          if (mem.data_gnt) begin
            state <= ST_WAIT;
            req_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem.data_rvalid) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ms_to_ws_valid && ws_allowin) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ysyx_22041752_msu_lsu_align u_align (
    .off         (pl.es_result[2:0]),
    .size        (pl.mem_size),
    .is_unsigned (pl.mem_unsigned),
    .st_data     (pl.store_data),
    .ld_word     (rbuf),
    .wstrb_c     (st_wstrb),
    .wdata_c     (st_wdata),
    .ld_r_c      (ld_r)
  );

  // Request fields come straight from the held payload, so they cannot move until gnt
  assign mem.data_req   = req_q && !reset;
  assign mem.data_wr    = pl.mem_we;
  assign mem.data_addr  = pl.es_result;
  assign mem.data_wdata = st_wdata;
  assign mem.data_wstrb = st_wstrb;

  assign ms_r = pl.mem_re ? ld_r : pl.es_result;

  always_comb begin
    ws_bus       = '0;
    ws_bus.rf_we = pl.rf_we & ~pl.mem_we;
    ws_bus.rd    = pl.rd;
    ws_bus.ms_r  = ms_r;
    ws_bus.pc    = pl.pc;
  end

  always_comb begin
    fwd           = '0;
    fwd.fwd_valid = !reset && ms_valid && ws_bus.rf_we;
    fwd.fwd_ready = ms_ready_go;
    fwd.ms_r      = ms_r;
    fwd.rd        = pl.rd;
  end

  assign ms_to_ws_bus   = ws_bus;
  assign ms_forward_bus = fwd;

endmodule
